// File: rtl/dram_axi_master.sv
// AXI4-Lite initiator that carries one 64-bit record read or write at a time
// between the core's command port and the DRAM channels.
module dram_axi_master (
  input  logic        clk,
  input  logic        rst,
  // core command port
  input  logic        C_in_valid,
  input  logic        C_r_wb,
  input  logic [7:0]  C_addr,
  input  logic [63:0] C_data_w,
  output logic        C_out_valid,
  output logic [63:0] C_data_r,
  output logic        C_err,
  output logic        C_busy,
  // read address / data
  output logic        AR_VALID,
  output logic [16:0] AR_ADDR,
  input  logic        AR_READY,
  input  logic        R_VALID,
  input  logic [63:0] R_DATA,
  input  logic [1:0]  R_RESP,
  output logic        R_READY,
  // write address / data / response
  output logic        AW_VALID,
  output logic [16:0] AW_ADDR,
  input  logic        AW_READY,
  output logic        W_VALID,
  output logic [63:0] W_DATA,
  input  logic        W_READY,
  input  logic        B_VALID,
  input  logic [1:0]  B_RESP,
  output logic        B_READY
);

  localparam logic [16:0] DRAM_BASE = 17'h10000;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (C_in_valid) state_nxt = C_r_wb ? S_AR : S_AW;
      S_AR:   if (AR_READY)   state_nxt = S_R;
      S_R:    if (R_VALID)    state_nxt = S_RESP;
      S_AW:   if (AW_READY)   state_nxt = S_W;
      S_W:    if (W_READY)    state_nxt = S_B;
      S_B:    if (B_VALID)    state_nxt = S_RESP;
      S_RESP:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset, since AR_ADDR, W_DATA and C_data_r
  // are visible outputs with defined reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && C_in_valid) begin
        addr_q  <= DRAM_BASE + {6'd0, C_addr, 3'b000};
        wdata_q <= C_data_w;
      end
      if (state == S_R && R_VALID) begin
        rdata_q <= R_DATA;
        err_q   <= (R_RESP != 2'b00);
      end
      // Writes report zero read data alongside the completion pulse.
      if (state == S_B && B_VALID) begin
        rdata_q <= '0;
        err_q   <= (B_RESP != 2'b00);
      end
    end
  end

  // Handshake outputs are pure decodes of the state register, so none of them
  // can combinationally follow the slave's READY/VALID.
  assign AR_VALID    = (state == S_AR);
  assign R_READY     = (state == S_R);
  assign AW_VALID    = (state == S_AW);
  assign W_VALID     = (state == S_W);
  assign B_READY     = (state == S_B);
  assign C_out_valid = (state == S_RESP);
  assign C_busy      = (state != S_IDLE);
  assign C_err       = C_out_valid & err_q;
  assign C_data_r    = rdata_q;
  assign AR_ADDR     = addr_q;
  assign AW_ADDR     = addr_q;
  assign W_DATA      = wdata_q;

endmodule

// File: tb/tb_dram_axi_master.sv
// Directed bench for dram_axi_master: stimulus changes and outputs are sampled
// on the falling edge, the DRAM slave is driven by hand from the sequence.
module tb_dram_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        C_in_valid, C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w, C_data_r;
  logic        C_out_valid, C_err, C_busy;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA;
  logic [1:0]  R_RESP, B_RESP;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_axi_master dut (
    .clk(clk), .rst(rst),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r), .C_err(C_err), .C_busy(C_busy),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Concatenation of every 1-bit handshake/status output, for idle checks.
  function automatic logic [8:0] ctl();
    return {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY,
            C_out_valid, C_err, C_busy, 1'b0};
  endfunction

  task automatic slave_tie(input logic v);
    AR_READY = v; R_VALID = v; AW_READY = v; W_READY = v; B_VALID = v;
  endtask

  // Issue one request and count cycles from the request edge to C_out_valid.
  task automatic run_req(input logic rwb, input logic [7:0] a, input logic [63:0] d,
                         output int lat);
    C_in_valid = 1'b1; C_r_wb = rwb; C_addr = a; C_data_w = d;
    tick();
    C_in_valid = 1'b0;
    lat = 1;
    while (!C_out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  int  lat;
  bit  bad;

  initial begin
    rst = 1'b1; C_in_valid = 1'b0; C_r_wb = 1'b0; C_addr = '0; C_data_w = '0;
    slave_tie(1'b0); R_DATA = '0; R_RESP = '0; B_RESP = '0;
    tick(); tick();
    rst = 1'b0;

    // ---- reset / idle
    repeat (5) tick();
    check("idle_ctl", ctl(), 9'd0);
    check("idle_ar_addr", AR_ADDR, 17'h0);
    check("idle_aw_addr", AW_ADDR, 17'h0);
    check("idle_w_data", W_DATA, 64'h0);
    check("idle_data_r", C_data_r, 64'h0);

    // ---- slow read, record 0x3A
    C_in_valid = 1'b1; C_r_wb = 1'b1; C_addr = 8'h3A;
    tick();
    C_in_valid = 1'b0;
    check("rd_ar_valid", AR_VALID, 1'b1);
    check("rd_ar_addr", AR_ADDR, 17'h101D0);
    check("rd_busy", C_busy, 1'b1);
    bad = 0;
    repeat (8) begin
      tick();
      if (!AR_VALID || AR_ADDR !== 17'h101D0 || R_READY) bad = 1;
    end
    check("rd_ar_hold", bad, 1'b0);
    AR_READY = 1'b1;
    tick();
    AR_READY = 1'b0;
    check("rd_ar_drop", AR_VALID, 1'b0);
    check("rd_r_ready", R_READY, 1'b1);
    bad = 0;
    repeat (8) begin
      tick();
      if (!R_READY || C_out_valid) bad = 1;
    end
    check("rd_r_hold", bad, 1'b0);
    R_VALID = 1'b1; R_DATA = 64'h0123_4567_89AB_CDEF; R_RESP = 2'b00;
    tick();
    R_VALID = 1'b0;
    check("rd_pulse", C_out_valid, 1'b1);
    check("rd_data", C_data_r, 64'h0123_4567_89AB_CDEF);
    check("rd_err", C_err, 1'b0);
    tick();
    check("rd_pulse_end", C_out_valid, 1'b0);
    check("rd_busy_end", C_busy, 1'b0);
    check("rd_data_hold", C_data_r, 64'h0123_4567_89AB_CDEF);

    // ---- slow write, record 0xFF
    C_in_valid = 1'b1; C_r_wb = 1'b0; C_addr = 8'hFF; C_data_w = 64'hDEAD_BEEF_0000_0001;
    tick();
    C_in_valid = 1'b0; C_data_w = '0;
    check("wr_aw_addr", AW_ADDR, 17'h107F8);
    bad = 0;
    repeat (8) begin
      if (!AW_VALID || W_VALID || AW_ADDR !== 17'h107F8) bad = 1;
      tick();
    end
    check("wr_aw_hold", bad, 1'b0);
    AW_READY = 1'b1;
    tick();
    AW_READY = 1'b0;
    check("wr_aw_drop", AW_VALID, 1'b0);
    check("wr_w_valid", W_VALID, 1'b1);
    check("wr_w_data", W_DATA, 64'hDEAD_BEEF_0000_0001);
    bad = 0;
    repeat (8) begin
      tick();
      if (!W_VALID || AW_VALID || B_READY || W_DATA !== 64'hDEAD_BEEF_0000_0001) bad = 1;
    end
    check("wr_w_hold", bad, 1'b0);
    W_READY = 1'b1;
    tick();
    W_READY = 1'b0;
    check("wr_b_ready", {W_VALID, B_READY}, 2'b01);
    repeat (8) tick();
    check("wr_b_wait", {B_READY, C_out_valid}, 2'b10);
    B_VALID = 1'b1; B_RESP = 2'b00;
    tick();
    B_VALID = 1'b0;
    check("wr_pulse", C_out_valid, 1'b1);
    check("wr_data_r", C_data_r, 64'h0);
    check("wr_err", C_err, 1'b0);
    tick();
    check("wr_pulse_end", ctl(), 9'd0);

    // ---- zero-wait slave, back-to-back
    slave_tie(1'b1); R_DATA = 64'hA5A5_0000_FFFF_1234; R_RESP = 2'b00; B_RESP = 2'b00;
    run_req(1'b1, 8'h01, 64'h0, lat);
    check("zw_rd_lat", lat, 3);
    check("zw_rd_data", C_data_r, 64'hA5A5_0000_FFFF_1234);
    tick();
    run_req(1'b0, 8'h02, 64'h1111_2222_3333_4444, lat);
    check("zw_wr_lat", lat, 4);
    check("zw_wr_data_r", C_data_r, 64'h0);

    // ---- error response then clean read
    tick();
    B_RESP = 2'b10;
    run_req(1'b0, 8'h10, 64'h5, lat);
    check("err_wr_lat", lat, 4);
    check("err_wr_err", C_err, 1'b1);
    B_RESP = 2'b00;
    tick();
    run_req(1'b1, 8'h11, 64'h0, lat);
    check("err_rd_lat", lat, 3);
    check("err_rd_err", C_err, 1'b0);
    tick();

    // ---- reset while in R
    slave_tie(1'b0);
    C_in_valid = 1'b1; C_r_wb = 1'b1; C_addr = 8'h20;
    tick();
    C_in_valid = 1'b0;
    AR_READY = 1'b1;
    tick();
    AR_READY = 1'b0;
    check("rst_in_r", R_READY, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ctl", ctl(), 9'd0);
    check("rst_ar_addr", AR_ADDR, 17'h0);
    check("rst_data_r", C_data_r, 64'h0);
    bad = 0;
    repeat (4) begin
      tick();
      if (C_out_valid || C_busy) bad = 1;
    end
    check("rst_no_pulse", bad, 1'b0);
    slave_tie(1'b1); R_DATA = 64'h0BAD_F00D_CAFE_0042;
    run_req(1'b1, 8'h21, 64'h0, lat);
    check("rst_fresh_lat", lat, 3);
    check("rst_fresh_data", C_data_r, 64'h0BAD_F00D_CAFE_0042);
    check("rst_fresh_addr", AR_ADDR, 17'h10108);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
